// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues aligned 64-bit fetches and feeds the instruction FIFO.
// Optional macro IF_MISALIGN_EXC_EN adds the misaligned-fetch exception path (ERR state, fetch_adel/fetch_badvaddr).
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_full,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fifo_rst,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [63:0] inst_rdata,
    output logic        write_en1,
    output logic        write_en2,
    output logic [31:0] write_address1,
    output logic [31:0] write_address2,
    output logic [31:0] write_data1,
    output logic [31:0] write_data2
`ifdef IF_MISALIGN_EXC_EN
    ,
    output logic        fetch_adel,
    output logic [31:0] fetch_badvaddr
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_KILL = 3'd3
`ifdef IF_MISALIGN_EXC_EN
        ,
        ST_ERR  = 3'd4
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        stale_q, stale_d;

    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic [31:0] pc_seq;
    logic [31:0] pc_seq_line;
    logic        resp_accept;

    // Without the exception path a redirect can never make the PC misaligned.
`ifdef IF_MISALIGN_EXC_EN
    assign redirect_target = redirect_pc;
`else
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign pc_plus4    = pc_q + 32'd4;
    assign pc_seq      = pc_q[2] ? pc_plus4 : (pc_q + 32'd8);
    assign pc_seq_line = {pc_seq[31:3], 3'b000};
    assign resp_accept = (state_q == ST_WAIT) && inst_data_ok && !redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= 32'h0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            stale_q    <= stale_d;
        end
    end

    // A redirect always wins over sequential PC advance; the stale flag remembers redirects seen while in REQ.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        stale_d    = stale_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
`ifdef IF_MISALIGN_EXC_EN
                end else if (pc_q[1:0] != 2'b00) begin
                    state_d = ST_ERR;
`endif
                end else if (!fifo_full) begin
                    req_addr_d = {pc_q[31:3], 3'b000};
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    stale_d = 1'b1;
                end
                if (inst_addr_ok) begin
                    state_d = (stale_q || redirect_valid) ? ST_KILL : ST_WAIT;
                    stale_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (resp_accept) begin
                    pc_d = pc_seq;
                    if (!fifo_full) begin
                        req_addr_d = pc_seq_line;
                        state_d    = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = inst_data_ok ? ST_IDLE : ST_KILL;
                end
            end
            ST_KILL: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (inst_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef IF_MISALIGN_EXC_EN
            ST_ERR: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        fifo_rst       = redirect_valid;
        inst_req       = (state_q == ST_REQ);
        inst_addr      = req_addr_q;
        write_en1      = 1'b0;
        write_en2      = 1'b0;
        write_address1 = 32'h0;
        write_address2 = 32'h0;
        write_data1    = 32'h0;
        write_data2    = 32'h0;
`ifdef IF_MISALIGN_EXC_EN
        fetch_adel     = 1'b0;
        fetch_badvaddr = 32'h0;
`endif
        if (resp_accept) begin
            write_en1      = 1'b1;
            write_address1 = pc_q;
            write_data1    = pc_q[2] ? inst_rdata[63:32] : inst_rdata[31:0];
            if (!pc_q[2]) begin
                write_en2      = 1'b1;
                write_address2 = pc_plus4;
                write_data2    = inst_rdata[63:32];
            end
        end
`ifdef IF_MISALIGN_EXC_EN
        // The faulting PC goes down the pipe as a null instruction carrying the exception.
        if ((state_q == ST_IDLE) && !redirect_valid && (pc_q[1:0] != 2'b00)) begin
            write_en1      = 1'b1;
            write_address1 = pc_q;
            write_data1    = 32'h0;
            fetch_adel     = 1'b1;
            fetch_badvaddr = pc_q;
        end
`endif
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed self-checking bench for if_fetch_ctrl; the IF_MISALIGN_EXC_EN section runs only when that macro is defined.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        fifo_full;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fifo_rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_rdata;
    logic        write_en1;
    logic        write_en2;
    logic [31:0] write_address1;
    logic [31:0] write_address2;
    logic [31:0] write_data1;
    logic [31:0] write_data2;
`ifdef IF_MISALIGN_EXC_EN
    logic        fetch_adel;
    logic [31:0] fetch_badvaddr;
`endif

    int vectors;
    int miscompares;

    if_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_full      (fifo_full),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fifo_rst       (fifo_rst),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .write_en1      (write_en1),
        .write_en2      (write_en2),
        .write_address1 (write_address1),
        .write_address2 (write_address2),
        .write_data1    (write_data1),
        .write_data2    (write_data2)
`ifdef IF_MISALIGN_EXC_EN
        ,
        .fetch_adel     (fetch_adel),
        .fetch_badvaddr (fetch_badvaddr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the falling edge; outputs are checked 1 time unit later.
    task automatic applyStimulus(input logic ff, input logic rv, input logic [31:0] rpc,
                                 input logic aok, input logic dok, input logic [63:0] rd);
        @(negedge clk);
        fifo_full      = ff;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_addr_ok   = aok;
        inst_data_ok   = dok;
        inst_rdata     = rd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkWrite(input string tag, input logic e1, input logic [31:0] a1, input logic [31:0] d1,
                              input logic e2, input logic [31:0] a2, input logic [31:0] d2);
        checkOutput({tag, "_we1"}, write_en1, e1);
        checkOutput({tag, "_wa1"}, write_address1, a1);
        checkOutput({tag, "_wd1"}, write_data1, d1);
        checkOutput({tag, "_we2"}, write_en2, e2);
        checkOutput({tag, "_wa2"}, write_address2, a2);
        checkOutput({tag, "_wd2"}, write_data2, d2);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b0;
        fifo_full      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_rdata     = 64'h0;

        // Reset: everything quiet except fifo_rst following redirect_valid
        applyStimulus(0, 1, 32'h1234_5678, 0, 0, 64'h0);
        checkOutput("rst_fifo_rst", fifo_rst, 1);
        checkOutput("rst_inst_req", inst_req, 0);
        checkOutput("rst_inst_addr", inst_addr, 32'h0);
        checkWrite("rst", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        checkOutput("rst_fifo_rst_low", fifo_rst, 0);
        rst = 1'b1;

        // First fetch from the reset PC, zero-wait-ish memory
        applyStimulus(0, 0, 0, 1, 0, 64'h0);
        checkOutput("first_req", inst_req, 1);
        checkOutput("first_addr", inst_addr, 32'hBFC0_0000);
        applyStimulus(0, 0, 0, 0, 1, 64'h2400_0002_2400_0001);
        checkOutput("first_resp_req", inst_req, 0);
        checkWrite("first_resp", 1, 32'hBFC0_0000, 32'h2400_0001, 1, 32'hBFC0_0004, 32'h2400_0002);

        // Request held stable until accepted
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        checkOutput("hold_req", inst_req, 1);
        checkOutput("hold_addr", inst_addr, 32'hBFC0_0008);
        applyStimulus(0, 0, 0, 1, 0, 64'h0);
        checkOutput("hold_addr2", inst_addr, 32'hBFC0_0008);

        // Response while FIFO full is still written, then IDLE
        applyStimulus(1, 0, 0, 0, 1, 64'h1111_2222_3333_4444);
        checkWrite("full_resp", 1, 32'hBFC0_0008, 32'h3333_4444, 1, 32'hBFC0_000C, 32'h1111_2222);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 64'h0);
            checkOutput("full_idle_req", inst_req, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        checkOutput("full_drop_req", inst_req, 0);
        applyStimulus(0, 0, 0, 1, 0, 64'h0);
        checkOutput("after_full_req", inst_req, 1);
        checkOutput("after_full_addr", inst_addr, 32'hBFC0_0010);

        // Redirect during WAIT: flush, stale response dropped, then new PC fetched
        applyStimulus(0, 1, 32'h8000_0200, 0, 0, 64'h0);
        checkOutput("wait_redir_fifo_rst", fifo_rst, 1);
        checkOutput("wait_redir_we1", write_en1, 0);
        applyStimulus(0, 0, 0, 0, 1, 64'hDEAD_BEEF_DEAD_BEEF);
        checkWrite("kill_drop", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        checkOutput("kill_idle_req", inst_req, 0);
        applyStimulus(0, 0, 0, 1, 0, 64'h0);
        checkOutput("wait_redir_addr", inst_addr, 32'h8000_0200);
        applyStimulus(1, 0, 0, 0, 1, 64'hAAAA_0001_BBBB_0002);
        checkWrite("wait_redir_resp", 1, 32'h8000_0200, 32'hBBBB_0002, 1, 32'h8000_0204, 32'hAAAA_0001);

        // Redirect from IDLE to an odd word: request at t+2, single write of the upper word
        applyStimulus(1, 1, 32'h8000_0104, 0, 0, 64'h0);
        checkOutput("idle_redir_fifo_rst", fifo_rst, 1);
        checkOutput("idle_redir_req", inst_req, 0);
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        checkOutput("idle_redir_t1_req", inst_req, 0);
        applyStimulus(0, 0, 0, 1, 0, 64'h0);
        checkOutput("idle_redir_t2_req", inst_req, 1);
        checkOutput("idle_redir_addr", inst_addr, 32'h8000_0100);
        applyStimulus(0, 0, 0, 0, 1, 64'hCAFE_0104_DEAD_0100);
        checkWrite("odd_resp", 1, 32'h8000_0104, 32'hCAFE_0104, 0, 0, 0);

        // Redirect coincident with addr_ok
        applyStimulus(0, 1, 32'h8000_0300, 1, 0, 64'h0);
        checkOutput("aok_redir_addr", inst_addr, 32'h8000_0108);
        checkOutput("aok_redir_fifo_rst", fifo_rst, 1);
        applyStimulus(0, 0, 0, 0, 1, 64'h1);
        checkWrite("aok_redir_drop", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, 1, 0, 64'h0);
        checkOutput("aok_redir_new_addr", inst_addr, 32'h8000_0300);

        // Redirect coincident with data_ok
        applyStimulus(0, 1, 32'h8000_0400, 0, 1, 64'h5A5A_5A5A_A5A5_A5A5);
        checkWrite("dok_redir_drop", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        checkOutput("dok_redir_idle_req", inst_req, 0);

        // Redirect earlier in REQ: request stays, later response killed
        applyStimulus(0, 1, 32'h8000_0504, 0, 0, 64'h0);
        checkOutput("req_redir_req", inst_req, 1);
        checkOutput("req_redir_addr", inst_addr, 32'h8000_0400);
        applyStimulus(0, 0, 0, 1, 0, 64'h0);
        checkOutput("req_redir_addr_held", inst_addr, 32'h8000_0400);
        applyStimulus(0, 0, 0, 0, 1, 64'h7);
        checkWrite("req_redir_drop", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, 1, 0, 64'h0);
        checkOutput("req_redir_new_addr", inst_addr, 32'h8000_0500);
        applyStimulus(1, 0, 0, 0, 1, 64'h0000_0504_0000_0500);
        checkWrite("req_redir_resp", 1, 32'h8000_0504, 32'h0000_0504, 0, 0, 0);

        // Address wrap at the top of the space
        applyStimulus(1, 1, 32'hFFFF_FFF8, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, 1, 0, 64'h0);
        checkOutput("wrap_addr", inst_addr, 32'hFFFF_FFF8);
        applyStimulus(0, 0, 0, 0, 1, 64'h0000_0002_0000_0001);
        checkWrite("wrap_resp", 1, 32'hFFFF_FFF8, 32'h0000_0001, 1, 32'hFFFF_FFFC, 32'h0000_0002);
        applyStimulus(0, 0, 0, 1, 0, 64'h0);
        checkOutput("wrap_next_addr", inst_addr, 32'h0000_0000);
        checkOutput("wrap_next_req", inst_req, 1);

        // Reset mid-transaction: back to IDLE, late response ignored
        applyStimulus(1, 0, 0, 0, 0, 64'h0);
        rst = 1'b0;
        #1;
        checkOutput("midrst_req", inst_req, 0);
        checkOutput("midrst_addr", inst_addr, 32'h0);
        applyStimulus(1, 0, 0, 0, 1, 64'h9999_8888_7777_6666);
        checkOutput("midrst_we1", write_en1, 0);
        rst = 1'b1;
        applyStimulus(1, 0, 0, 0, 1, 64'h9999_8888_7777_6666);
        checkWrite("midrst_late_resp", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        checkOutput("midrst_idle_req", inst_req, 0);
        applyStimulus(0, 0, 0, 1, 0, 64'h0);
        checkOutput("midrst_refetch", inst_addr, 32'hBFC0_0000);
        applyStimulus(1, 0, 0, 0, 1, 64'h0);
        checkOutput("midrst_resp_we1", write_en1, 1);

`ifdef IF_MISALIGN_EXC_EN
        // Misaligned redirect raises one exception entry and parks in ERR
        applyStimulus(1, 1, 32'h8000_0002, 0, 0, 64'h0);
        applyStimulus(1, 0, 0, 0, 0, 64'h0);
        checkOutput("adel_req", inst_req, 0);
        checkWrite("adel", 1, 32'h8000_0002, 32'h0, 0, 0, 0);
        checkOutput("adel_flag", fetch_adel, 1);
        checkOutput("adel_badvaddr", fetch_badvaddr, 32'h8000_0002);
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        checkOutput("err_req", inst_req, 0);
        checkOutput("err_we1", write_en1, 0);
        checkOutput("err_adel", fetch_adel, 0);
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        checkOutput("err_req2", inst_req, 0);
        applyStimulus(0, 1, 32'h8000_0000, 0, 0, 64'h0);
        checkOutput("err_exit_fifo_rst", fifo_rst, 1);
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        checkOutput("err_exit_idle_req", inst_req, 0);
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        checkOutput("err_exit_req", inst_req, 1);
        checkOutput("err_exit_addr", inst_addr, 32'h8000_0000);
`else
        // Low PC bits of a redirect are dropped
        applyStimulus(1, 1, 32'h8000_0606, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, 0, 0, 64'h0);
        applyStimulus(0, 0, 0, 1, 0, 64'h0);
        checkOutput("mask_addr", inst_addr, 32'h8000_0600);
        applyStimulus(1, 0, 0, 0, 1, 64'h5555_0604_6666_0600);
        checkWrite("mask_resp", 1, 32'h8000_0604, 32'h5555_0604, 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
